// File: rtl/serial_subtractor.sv
// serial_subtractor: computes A - B as A + ~B + 1, CHUNK bits per clock,
// least significant chunk first. Result, carry-out and the compare flags
// (not-equal, signed less-than, signed overflow) are registered. They are
// valid in the single DONE cycle and hold until the next accepted start.
// WIDTH must be an integer multiple of CHUNK.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_result,
  output logic             sub_cout,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;          // latched minuend
  logic [WIDTH-1:0] opb_inv;      // latched ones' complement of subtrahend
  logic             carry;        // carry into the chunk being processed
  logic [CNT_W-1:0] cnt;          // index of the chunk being processed

  int               chunk_base;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] result_next;
  logic             last_chunk;
  logic             ovf_next;

  // Signed overflow of a - b: the operands differ in sign and the result
  // takes the sign of the subtrahend.
  function automatic logic sub_overflow(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // One chunk of the ripple: A chunk + ~B chunk + carry, merged into the
  // partial result so the flags can be formed from the complete value on
  // the cycle the last chunk lands.
  always_comb begin
    chunk_base  = int'(cnt) * CHUNK;
    chunk_sum   = {1'b0, opa[chunk_base +: CHUNK]}
                + {1'b0, opb_inv[chunk_base +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
    result_next = data_result;
    result_next[chunk_base +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_chunk  = (cnt == LAST_CNT);
    ovf_next    = sub_overflow(opa, ~opb_inv, result_next);
  end

  // Control FSM with registered status, result and flag outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      opa         <= '0;
      opb_inv     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_result <= '0;
      sub_cout    <= 1'b0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa     <= data_operandA;
            opb_inv <= ~data_operandB;
            carry   <= 1'b1;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          data_result <= result_next;
          carry       <= chunk_sum[CHUNK];
          cnt         <= cnt + 1'b1;
          if (last_chunk) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            sub_cout   <= chunk_sum[CHUNK];
            overflow   <= ovf_next;
            isLessThan <= result_next[WIDTH-1] ^ ovf_next;
            isNotEqual <= ~(chunk_sum[CHUNK] & (result_next == '0));
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a scoreboard of expected
// results filled at launch and drained when done is seen.
module tb_serial_subtractor;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         busy;
  logic         done;
  logic [W-1:0] data_result;
  logic         sub_cout;
  logic         isNotEqual;
  logic         isLessThan;
  logic         overflow;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ne;
    logic         lt;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .busy          (busy),
    .done          (done),
    .data_result   (data_result),
    .sub_cout      (sub_cout),
    .isNotEqual    (isNotEqual),
    .isLessThan    (isLessThan),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, ~b} + 33'd1;
    e.res  = a - b;
    e.cout = full[W];
    e.ne   = (a != b);
    e.lt   = ($signed(a) < $signed(b));
    e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive start with operands for one edge; optionally record the expectation.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    start         = 1'b1;
    data_operandA = a;
    data_operandB = b;
    if (push) q.push_back(model(a, b));
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Wait for done on falling edges, checking latency, busy length and results.
  task automatic wait_check(input string tag, input int exp_lat);
    int n = 0;
    int busy_n = 0;
    bit got = 0;
    exp_t e;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        n = i;
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
      chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
      chk({tag, "_queue_nonempty"}, 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({tag, "_result"}, 64'(data_result), 64'(e.res));
        chk({tag, "_sub_cout"}, 64'(sub_cout), 64'(e.cout));
        chk({tag, "_isNotEqual"}, 64'(isNotEqual), 64'(e.ne));
        chk({tag, "_isLessThan"}, 64'(isLessThan), 64'(e.lt));
        chk({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(data_result), 64'd0);
    chk({tag, "_sub_cout"}, 64'(sub_cout), 64'd0);
    chk({tag, "_isNotEqual"}, 64'(isNotEqual), 64'd0);
    chk({tag, "_isLessThan"}, 64'(isLessThan), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    int done_seen;

    reset         = 1'b1;
    start         = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");

    // reset wins over start
    start         = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd2;
    @(posedge clock); #1;
    chk("reset_priority_busy", 64'(busy), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    // equal operands, then hold check after the done pulse
    launch(32'd5, 32'd5, 1'b1);
    wait_check("eq5", 5);
    held = data_result;
    @(negedge clock);
    chk("eq5_done_pulse_one_cycle", 64'(done), 64'd0);
    chk("eq5_result_held", 64'(data_result), 64'(held));
    chk("eq5_flag_held", 64'(isNotEqual), 64'd0);

    launch(32'd3, 32'd7, 1'b1);
    wait_check("3m7", 5);
    launch(32'h8000_0000, 32'd1, 1'b1);
    wait_check("minneg", 5);
    launch(32'h0000_00FF, 32'd1, 1'b1);
    wait_check("ff_m1", 5);
    launch(32'h0000_0100, 32'd1, 1'b1);
    wait_check("ripple", 5);
    launch(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_check("posovf", 5);
    launch(32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_check("zm1", 5);

    // start held high through RUN with changing operands
    launch(32'd1000, 32'd1, 1'b1);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      @(posedge clock); #1;
    end
    start = 1'b0;
    wait_check("start_held", 1);

    // back-to-back: start presented during the DONE cycle
    launch(32'h1234_5678, 32'h0000_1111, 1'b1);
    wait_check("b2b_first", 5);
    launch(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    chk("b2b_no_idle_busy", 64'(busy), 64'd1);
    chk("b2b_done_dropped", 64'(done), 64'd0);
    wait_check("b2b_second", 5);

    // a few random operands
    for (int r = 0; r < 4; r++) begin
      launch($urandom, $urandom, 1'b1);
      wait_check("random", 5);
    end

    // reset on the second RUN cycle aborts without done
    launch(32'd77, 32'd11, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_all_zero("abort");
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    launch(32'd77, 32'd11, 1'b1);
    wait_check("after_abort", 5);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
